// File: rtl/axis_flit_injector_pkg.sv
// Shared NoC definitions: holding-register state and credit-counter sizing.
package axis_flit_injector_pkg;

  // Occupancy of the single-beat holding register.
  typedef enum logic {
    EMPTY  = 1'b0,
    LOADED = 1'b1
  } hold_state_e;

  // Bits needed to hold a credit count ranging over 0..depth inclusive.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/axis_flit_injector_credit_counter.sv
// Credit counter for a credit-based NoC link. It starts full at DEPTH,
// drops by one per flit sent and rises by one per credit returned.
// Shared by the ingress (injector) and egress sides of the router port.
module credit_counter #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] FULL = WIDTH'(DEPTH);

  // Track downstream buffer space; a simultaneous send and return cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers are updated with <= so every flop samples pre-edge values.
    if (!rst_n) begin
      count <= FULL;
    end else if (inc && !dec) begin
      if (count != FULL) count <= count + 1'b1;
    end else if (dec && !inc) begin
      count <= count - 1'b1;
    end
  end

  // A credit returned while the count is already full is a downstream
  // protocol error; the counter saturates rather than wrapping.
  no_credit_overflow: assert property (
    @(posedge clk) disable iff (!rst_n) !(inc && !dec && count == FULL)
  );

endmodule

// File: rtl/axis_flit_injector.sv
// AXI-Stream to NoC flit injector. Each accepted beat is held and split into
// SERIALIZATION_FACTOR flits, lowest slice first, issued one per cycle while
// the downstream input buffer has credit.
module axis_flit_injector
  import axis_flit_injector_pkg::*;
#(
  parameter int TDATA_WIDTH          = 64,
  parameter int SERIALIZATION_FACTOR = 2,
  parameter int DEST_WIDTH           = 6,
  parameter int FLIT_BUFFER_DEPTH    = 8,
  localparam int FLIT_WIDTH          = TDATA_WIDTH / SERIALIZATION_FACTOR,
  localparam int CREDIT_WIDTH        = credit_width(FLIT_BUFFER_DEPTH)
) (
  input  logic                    clk_noc,
  input  logic                    rst_n,
  input  logic                    axis_tvalid,
  output logic                    axis_tready,
  input  logic [TDATA_WIDTH-1:0]  axis_tdata,
  input  logic                    axis_tlast,
  input  logic [DEST_WIDTH-1:0]   axis_tdest,
  output logic [FLIT_WIDTH-1:0]   data_out,
  output logic [DEST_WIDTH-1:0]   dest_out,
  output logic                    is_tail_out,
  output logic                    send_out,
  input  logic                    credit_in,
  output logic [CREDIT_WIDTH-1:0] credits_avail
);

  localparam int IDX_WIDTH = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(SERIALIZATION_FACTOR - 1);

  hold_state_e                                     state;
  logic [SERIALIZATION_FACTOR-1:0][FLIT_WIDTH-1:0] held_flits;
  logic                                            held_last;
  logic [DEST_WIDTH-1:0]                           held_dest;
  logic [IDX_WIDTH-1:0]                            idx;
  logic [CREDIT_WIDTH-1:0]                         credits;
  logic                                            issue;
  logic                                            last_flit;
  logic                                            accept;

  // Issue is gated by the registered credit count, so a returned credit
  // only takes effect in the cycle after it arrives.
  assign issue         = (state == LOADED) && (credits != '0);
  assign last_flit     = (idx == LAST_IDX);
  assign axis_tready   = (state == EMPTY) || (issue && last_flit);
  assign accept        = axis_tvalid && axis_tready;
  assign credits_avail = credits;

  // Holding register: capture a beat on acceptance, free it after its last flit.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      held_flits <= '0;
      held_last  <= 1'b0;
      held_dest  <= '0;
    end else if (accept) begin
      state      <= LOADED;
      held_flits <= axis_tdata;
      held_last  <= axis_tlast;
      held_dest  <= axis_tdest;
    end else if (issue && last_flit) begin
      state <= EMPTY;
    end
  end

  generate
    if (SERIALIZATION_FACTOR > 1) begin : g_idx
      // Flit index: restart on every new beat, advance on every issued flit.
      always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n)      idx <= '0;
        else if (accept) idx <= '0;
        else if (issue)  idx <= idx + 1'b1;
      end
    end else begin : g_no_idx
      // A beat is a single flit, so there is nothing to count.
      assign idx = '0;
    end
  endgenerate

  // Registered flit outputs; payload fields hold their last value between flits.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      send_out    <= 1'b0;
      data_out    <= '0;
      dest_out    <= '0;
      is_tail_out <= 1'b0;
    end else begin
      send_out <= issue;
      if (issue) begin
        data_out    <= held_flits[idx];
        dest_out    <= held_dest;
        is_tail_out <= held_last && last_flit;
      end
    end
  end

  credit_counter #(
    .DEPTH (FLIT_BUFFER_DEPTH),
    .WIDTH (CREDIT_WIDTH)
  ) u_credits (
    .clk   (clk_noc),
    .rst_n (rst_n),
    .dec   (issue),
    .inc   (credit_in),
    .count (credits)
  );

endmodule

// File: tb/tb_axis_flit_injector.sv
// Scoreboard bench for axis_flit_injector: accepted beats are expanded into
// expected flits by a reference model; a monitor pops and compares each flit.
module tb_axis_flit_injector;

  localparam int TW    = 64;
  localparam int SF    = 2;
  localparam int DW    = 6;
  localparam int DEPTH = 8;
  localparam int FW    = TW / SF;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk_noc = 1'b0;
  logic          rst_n   = 1'b0;
  logic          axis_tvalid = 1'b0;
  logic          axis_tready;
  logic [TW-1:0] axis_tdata = '0;
  logic          axis_tlast = 1'b0;
  logic [DW-1:0] axis_tdest = '0;
  logic [FW-1:0] data_out;
  logic [DW-1:0] dest_out;
  logic          is_tail_out;
  logic          send_out;
  logic          credit_in;
  logic [CW-1:0] credits_avail;

  logic pulse_c = 1'b0;
  logic ret_c   = 1'b0;
  assign credit_in = pulse_c | ret_c;

  axis_flit_injector #(
    .TDATA_WIDTH          (TW),
    .SERIALIZATION_FACTOR (SF),
    .DEST_WIDTH           (DW),
    .FLIT_BUFFER_DEPTH    (DEPTH)
  ) dut (
    .clk_noc       (clk_noc),
    .rst_n         (rst_n),
    .axis_tvalid   (axis_tvalid),
    .axis_tready   (axis_tready),
    .axis_tdata    (axis_tdata),
    .axis_tlast    (axis_tlast),
    .axis_tdest    (axis_tdest),
    .data_out      (data_out),
    .dest_out      (dest_out),
    .is_tail_out   (is_tail_out),
    .send_out      (send_out),
    .credit_in     (credit_in),
    .credits_avail (credits_avail)
  );

  always #5 clk_noc = ~clk_noc;

  typedef struct {
    logic [FW-1:0] data;
    logic [DW-1:0] dest;
    logic          tail;
  } flit_t;

  flit_t sb[$];
  int    send_cycles[$];
  int    accept_cycles[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_flits  = 0;
  int    cyc      = 0;
  bit    ret_mode = 1'b0;
  bit    chk3     = 1'b0;

  always @(posedge clk_noc) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a beat becomes SF flits, lowest slice first; only the
  // final flit of a tlast beat is a tail.
  task automatic push_beat(input logic [TW-1:0] d, input logic l, input logic [DW-1:0] dst);
    flit_t f;
    for (int i = 0; i < SF; i++) begin
      f.data = FW'(d >> (i * FW));
      f.dest = dst;
      f.tail = l && (i == SF - 1);
      sb.push_back(f);
    end
  endtask

  // Monitor: record accepted beats, compare every emitted flit, and act as the
  // downstream buffer returning a credit for each flit when ret_mode is set.
  always @(negedge clk_noc) begin
    flit_t e;
    if (!rst_n) begin
      ret_c = 1'b0;
    end else begin
      if (axis_tvalid && axis_tready) begin
        push_beat(axis_tdata, axis_tlast, axis_tdest);
        accept_cycles.push_back(cyc);
      end
      if (send_out) begin
        n_flits++;
        send_cycles.push_back(cyc);
        if (sb.size() == 0) begin
          check("unexpected_flit", 64'(send_out), 64'd0);
        end else begin
          e = sb.pop_front();
          check("flit_data", 64'(data_out), 64'(e.data));
          check("flit_dest", 64'(dest_out), 64'(e.dest));
          check("flit_tail", 64'(is_tail_out), 64'(e.tail));
        end
        if (chk3) check("credits_hold_at_3", 64'(credits_avail), 64'd3);
      end
      ret_c = ret_mode && send_out;
    end
  end

  // Present one beat (tvalid stays high afterwards) and wait for acceptance.
  task automatic drive_beat(input logic [TW-1:0] d, input logic l, input logic [DW-1:0] dst);
    bit ok;
    axis_tdata  = d;
    axis_tlast  = l;
    axis_tdest  = dst;
    axis_tvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk_noc);
      ok = axis_tready;
      @(posedge clk_noc);
      #1;
    end
    if (!ok) check("accept_timeout", 64'(axis_tready), 64'd1);
  endtask

  task automatic drive_random_beat();
    drive_beat({$urandom(), $urandom()}, 1'($urandom_range(0, 1)), DW'($urandom_range(0, 63)));
  endtask

  task automatic pulse_credit(output int pc);
    @(posedge clk_noc);
    #1;
    pc = cyc;
    pulse_c = 1'b1;
    @(posedge clk_noc);
    #1;
    pulse_c = 1'b0;
  endtask

  task automatic idle(input int n);
    axis_tvalid = 1'b0;
    repeat (n) @(posedge clk_noc);
    #1;
  endtask

  initial begin
    int base_f, base_s, base_a, pc;
    bit seen;

    repeat (3) @(posedge clk_noc);
    @(negedge clk_noc);
    rst_n = 1'b1;
    @(negedge clk_noc);
    #1;
    check("reset_send_out", 64'(send_out), 64'd0);
    check("reset_data_out", 64'(data_out), 64'd0);
    check("reset_dest_out", 64'(dest_out), 64'd0);
    check("reset_is_tail", 64'(is_tail_out), 64'd0);
    check("reset_credits", 64'(credits_avail), 64'd8);
    check("reset_tready", 64'(axis_tready), 64'd1);
    @(posedge clk_noc);
    #1;

    // Single tail beat split into two back-to-back flits.
    base_f = n_flits;
    base_s = send_cycles.size();
    drive_beat(64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 6'h2A);
    idle(8);
    check("single_beat_flits", 64'(n_flits - base_f), 64'd2);
    if (send_cycles.size() >= base_s + 2)
      check("single_beat_consecutive", 64'(send_cycles[base_s+1] - send_cycles[base_s]), 64'd1);
    check("single_beat_credits", 64'(credits_avail), 64'd6);
    pulse_credit(pc);
    pulse_credit(pc);
    idle(2);
    check("credits_restored", 64'(credits_avail), 64'd8);

    // Five beats with no returned credit: exactly eight flits leave.
    base_f = n_flits;
    for (int i = 0; i < 5; i++) drive_random_beat();
    idle(10);
    check("starved_flits", 64'(n_flits - base_f), 64'd8);
    check("starved_credits", 64'(credits_avail), 64'd0);
    check("starved_tready", 64'(axis_tready), 64'd0);
    check("starved_send_out", 64'(send_out), 64'd0);
    check("starved_pending", 64'(sb.size()), 64'd2);

    // One credit at count 0 releases exactly one flit two cycles later.
    base_f = n_flits;
    pulse_credit(pc);
    idle(6);
    check("one_credit_flits", 64'(n_flits - base_f), 64'd1);
    if (send_cycles.size() > 0)
      check("one_credit_latency", 64'(send_cycles[$] - pc), 64'd2);
    check("one_credit_credits", 64'(credits_avail), 64'd0);
    pulse_credit(pc);
    idle(4);
    check("drain_pending", 64'(sb.size()), 64'd0);
    for (int i = 0; i < 8; i++) pulse_credit(pc);
    idle(2);
    check("refill_credits", 64'(credits_avail), 64'd8);

    // Bring the count to 4 so streaming with immediate returns sits at 3.
    drive_random_beat();
    drive_random_beat();
    idle(8);
    check("prestream_credits", 64'(credits_avail), 64'd4);

    ret_mode = 1'b1;
    chk3     = 1'b1;
    base_f = n_flits;
    base_s = send_cycles.size();
    base_a = accept_cycles.size();
    for (int i = 0; i < 6; i++) drive_random_beat();
    idle(10);
    ret_mode = 1'b0;
    chk3     = 1'b0;
    check("stream_flits", 64'(n_flits - base_f), 64'd12);
    if (send_cycles.size() >= base_s + 12)
      check("stream_no_bubble", 64'(send_cycles[base_s+11] - send_cycles[base_s]), 64'd11);
    for (int i = base_a + 1; i < accept_cycles.size(); i++)
      check("stream_tready_period", 64'(accept_cycles[i] - accept_cycles[i-1]), 64'd2);
    check("stream_credits", 64'(credits_avail), 64'd4);

    // Reset after the first flit of a beat: the second flit never appears.
    base_f = n_flits;
    drive_beat({$urandom(), $urandom()}, 1'b1, 6'h15);
    axis_tvalid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk_noc);
      seen = send_out;
    end
    if (!seen) check("reset_wait_timeout", 64'(send_out), 64'd1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midreset_send_out", 64'(send_out), 64'd0);
    check("midreset_data_out", 64'(data_out), 64'd0);
    check("midreset_dest_out", 64'(dest_out), 64'd0);
    check("midreset_is_tail", 64'(is_tail_out), 64'd0);
    check("midreset_credits", 64'(credits_avail), 64'd8);
    repeat (2) @(posedge clk_noc);
    @(negedge clk_noc);
    rst_n = 1'b1;
    idle(10);
    check("midreset_flits", 64'(n_flits - base_f), 64'd1);
    check("midreset_tready", 64'(axis_tready), 64'd1);
    check("final_pending", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
